// File: rtl/led_pwm_driver_pkg.sv
// led_pkg: register map, control bit positions and blink states shared by the LED PWM driver
package led_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int BREATH_BITS = 8;
    localparam logic [ADDR_W-1:0] ADDR_CTRL        = 5'h00;
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE    = 5'h01;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_ON    = 5'h02;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_OFF   = 5'h03;
    localparam logic [ADDR_W-1:0] ADDR_BREATH_RATE = 5'h04;
    localparam logic [ADDR_W-1:0] ADDR_DUTY_BASE   = 5'h10;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_BREATHE = 1;
    localparam int CTRL_BLINK   = 2;
    typedef enum logic {
        BLINK_ST_ON  = 1'b0,
        BLINK_ST_OFF = 1'b1
    } blink_state_e;
endpackage

// File: rtl/led_pwm_driver_if.sv
// led_pwm_driver_if: register write bus from the SPI/UART decoder into the LED driver
interface led_pwm_driver_if;
    import led_pkg::*;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/led_pwm_driver_channel.sv
// led_pwm_channel: one PWM output with shadowed duty, breathe clipping and registered compare
module led_pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                duty_we,
    input  logic [PWM_BITS-1:0] duty_data,
    input  logic                commit,
    input  logic                breathe_en,
    input  logic [PWM_BITS-1:0] level,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                gate,
    output logic                pwm_out
);
    logic [PWM_BITS-1:0] shadow, active, eff;

    assign eff = (breathe_en && level < active) ? level : active;

    // writes land in the shadow; the active duty only reloads at a frame wrap or while disabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (duty_we) shadow <= duty_data;
            if (commit) active <= shadow;
        end
    end

    // registered compare keeps the pad output glitch-free
    always_ff @(posedge clk) begin
        if (!rst_n) pwm_out <= 1'b0;
        else pwm_out <= gate && (pwm_cnt < eff);
    end
endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: multi-channel LED PWM with prescaler, frame counter, breathe and blink envelopes
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int CHANNELS   = 3,
    parameter int PWM_BITS   = 8,
    parameter int PRESC_BITS = 10,
    parameter int BLINK_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    led_pwm_driver_if.slave     bus,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                led_on,
    output logic                frame_start
);
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
    localparam int BW = BLINK_BITS + 1;

    logic [2:0]             ctrl;
    logic [PRESC_BITS-1:0]  presc, presc_cnt;
    logic [BLINK_BITS-1:0]  blink_on_len, blink_off_len, blink_cnt;
    logic [BW-1:0]          blink_nxt;
    logic [BREATH_BITS-1:0] breath_rate, breath_cnt;
    logic [PWM_BITS-1:0]    pwm_cnt, level;
    logic                   level_down, blink_armed, blink_done;
    blink_state_e           blink_st;
    logic                   enable, breathe_en, blink_en, tick, wrap, blink_phase, gate;

    assign enable      = ctrl[CTRL_EN];
    assign breathe_en  = ctrl[CTRL_BREATHE];
    assign blink_en    = ctrl[CTRL_BLINK];
    assign tick        = enable && presc_cnt >= presc;
    assign wrap        = tick && pwm_cnt == PWM_MAX;
    assign blink_phase = !blink_en || (blink_st == BLINK_ST_ON && blink_on_len != '0);
    assign gate        = enable && blink_phase;
    assign blink_nxt   = {1'b0, blink_cnt} + BW'(1);
    assign blink_done  = blink_nxt >= {1'b0, (blink_st == BLINK_ST_ON) ? blink_on_len : blink_off_len};

    // register file; unmapped addresses fall through untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl          <= '0;
            presc         <= '0;
            blink_on_len  <= '0;
            blink_off_len <= '0;
            breath_rate   <= '0;
        end else if (bus.wr_en) begin
            if (bus.wr_addr == ADDR_CTRL) ctrl <= bus.wr_data[2:0];
            if (bus.wr_addr == ADDR_PRESCALE) presc <= bus.wr_data[PRESC_BITS-1:0];
            if (bus.wr_addr == ADDR_BLINK_ON) blink_on_len <= bus.wr_data[BLINK_BITS-1:0];
            if (bus.wr_addr == ADDR_BLINK_OFF) blink_off_len <= bus.wr_data[BLINK_BITS-1:0];
            if (bus.wr_addr == ADDR_BREATH_RATE) breath_rate <= bus.wr_data[BREATH_BITS-1:0];
        end
    end

    // prescaler and frame counter; >= lets a smaller PRESCALE take effect without a long wrap
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + PRESC_BITS'(1);
            pwm_cnt   <= pwm_cnt + PWM_BITS'(tick);
        end
    end

    // frame boundary pulse and envelope flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
            led_on      <= 1'b0;
        end else begin
            frame_start <= wrap;
            led_on      <= gate;
        end
    end

    // breathe triangle: one step every BREATH_RATE+1 frames, endpoints held for one step
    always_ff @(posedge clk) begin
        if (!rst_n || !enable || !breathe_en) begin
            level      <= '0;
            level_down <= 1'b0;
            breath_cnt <= '0;
        end else if (wrap) begin
            breath_cnt <= (breath_cnt >= breath_rate) ? '0 : breath_cnt + BREATH_BITS'(1);
            if (breath_cnt >= breath_rate) begin
                level      <= level_down ? ((level == '0) ? level : level - PWM_BITS'(1))
                                         : ((level == PWM_MAX) ? level : level + PWM_BITS'(1));
                level_down <= level_down ? (level != '0) : (level == PWM_MAX);
            end
        end
    end

    // blink envelope: armed by the first wrap after blink_en, then counts whole frames per phase
    always_ff @(posedge clk) begin
        if (!rst_n || !enable || !blink_en) begin
            blink_st    <= BLINK_ST_ON;
            blink_cnt   <= '0;
            blink_armed <= 1'b0;
        end else if (wrap) begin
            blink_armed <= 1'b1;
            if (blink_armed) begin
                blink_cnt <= blink_done ? '0 : blink_nxt[BLINK_BITS-1:0];
                if (blink_done) blink_st <= (blink_st == BLINK_ST_ON && blink_off_len != '0) ? BLINK_ST_OFF : BLINK_ST_ON;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .duty_we    (bus.wr_en && bus.wr_addr == ADDR_DUTY_BASE + ADDR_W'(c)),
            .duty_data  (bus.wr_data[PWM_BITS-1:0]),
            .commit     (wrap || !enable),
            .breathe_en (breathe_en),
            .level      (level),
            .pwm_cnt    (pwm_cnt),
            .gate       (gate),
            .pwm_out    (pwm_out[c])
        );
    end
endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: randomized scoreboard bench against a frame-arithmetic reference model
module tb_led_pwm_driver;
    localparam int CH = 3;
    localparam int MAXV = 255;
    localparam int FRAME = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CH-1:0] pwm_out;
    logic led_on, frame_start;

    led_pwm_driver_if bus();

    led_pwm_driver #(.CHANNELS(CH), .PWM_BITS(8), .PRESC_BITS(10), .BLINK_BITS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .pwm_out     (pwm_out),
        .led_on      (led_on),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] pwm;
        logic          led;
        logic          fs;
    } obs_t;

    obs_t exp_q[$];
    obs_t got, want;
    int checks = 0;
    int errors = 0;

    bit m_en, m_br, m_bl, m_armed;
    int m_presc, m_bon, m_boff, m_brate;
    int m_s, m_ticks, m_nbr, m_nbl;
    int m_shadow[CH];
    int m_active[CH];

    function automatic int tri_level(input int steps);
        int t;
        t = steps % (2 * FRAME);
        return (t <= MAXV) ? t : 2 * MAXV + 1 - t;
    endfunction

    // one clock of the reference: outputs from the pre-edge state, then state advance and writes
    task automatic model_step(input bit rs, input bit we, input int addr, input int data);
        obs_t e;
        bit tick, wrap, ph;
        int cnt, lvl, eff;
        e = '0;
        if (!rs) begin
            {m_en, m_br, m_bl, m_armed} = '0;
            {m_presc, m_bon, m_boff, m_brate, m_s, m_ticks, m_nbr, m_nbl} = '0;
            for (int c = 0; c < CH; c++) begin
                m_shadow[c] = 0;
                m_active[c] = 0;
            end
        end else begin
            tick = m_en && m_s >= m_presc;
            cnt  = m_ticks % FRAME;
            wrap = tick && cnt == MAXV;
            lvl  = m_br ? tri_level(m_nbr / (m_brate + 1)) : 0;
            ph   = !m_bl || (m_bon != 0 && (!m_armed || m_boff == 0 || (m_nbl % (m_bon + m_boff)) < m_bon));
            for (int c = 0; c < CH; c++) begin
                eff = (m_br && lvl < m_active[c]) ? lvl : m_active[c];
                e.pwm[c] = m_en && ph && cnt < eff;
            end
            e.led = m_en && ph;
            e.fs  = wrap;
            m_s     = (!m_en || tick) ? 0 : m_s + 1;
            m_ticks = m_en ? m_ticks + int'(tick) : 0;
            m_nbl   = (m_en && m_bl) ? m_nbl + int'(m_armed && wrap) : 0;
            m_armed = m_en && m_bl && (m_armed || wrap);
            m_nbr   = (m_en && m_br) ? m_nbr + int'(wrap) : 0;
            if (!m_en || wrap)
                for (int c = 0; c < CH; c++) m_active[c] = m_shadow[c];
            if (we) begin
                if (addr == 0) {m_bl, m_br, m_en} = 3'(data);
                if (addr == 1) m_presc = data & 'h3FF;
                if (addr == 2) m_bon = data & 'hFF;
                if (addr == 3) m_boff = data & 'hFF;
                if (addr == 4) m_brate = data & 'hFF;
                if (addr >= 'h10 && addr < 'h10 + CH) m_shadow[addr - 'h10] = data & 'hFF;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit rs, input bit we, input int addr, input int data);
        @(negedge clk);
        rst_n       = rs;
        bus.wr_en   = we;
        bus.wr_addr = 5'(addr);
        bus.wr_data = 16'(data);
        model_step(rs, we, addr, data);
    endtask

    task automatic wr(input int addr, input int data);
        cyc(1'b1, 1'b1, addr, data);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 0, 0);
    endtask

    // monitor: pops the expected outputs for every clock the DUT has advanced
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {pwm_out, led_on, frame_start};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL outputs t=%0t got pwm=%b led=%b fs=%b want pwm=%b led=%b fs=%b",
                         $time, got.pwm, got.led, got.fs, want.pwm, want.led, want.fs);
            end
        end
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        repeat (3) cyc(1'b0, 1'b0, 0, 0);
        idle(2);

        wr('h01, 0);
        wr('h10, 64);
        wr('h11, int'($urandom_range(1, 254)));
        wr('h12, 255);
        wr('h00, 1);
        idle(100);
        wr('h11, 200);
        for (int i = 0; i < 2000 && m_ticks % FRAME != MAXV; i++) idle(1);
        wr('h10, int'($urandom_range(0, 255)));
        idle(600);

        wr('h01, 9);
        for (int i = 0; i < 50 && m_s != 7; i++) idle(1);
        wr('h01, 3);
        idle(300);

        for (int i = 0; i < 150; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4) wr('h10 + int'($urandom_range(0, 15)), int'($urandom_range(0, 'hFFFF)));
            else if (r == 4) wr('h01, int'($urandom_range(0, 3)));
            else if (r == 5) wr('h00, int'($urandom_range(0, 1)));
            else if (r == 6) wr(int'($urandom_range(5, 15)), int'($urandom_range(0, 'hFFFF)));
            else if (r == 7) cyc(1'b0, 1'b0, 0, 0);
            idle(int'($urandom_range(0, 60)));
        end

        wr('h00, 0);
        wr('h01, 0);
        wr('h02, 2);
        wr('h03, 3);
        wr('h10, 255);
        wr('h00, 5);
        idle(FRAME * 13);
        wr('h00, 1);
        wr('h02, 0);
        wr('h00, 5);
        idle(FRAME * 2 + 40);
        wr('h00, 1);
        wr('h02, 3);
        wr('h03, 0);
        wr('h00, 5);
        idle(FRAME * 5);
        wr('h00, 1);
        wr('h02, int'($urandom_range(1, 3)));
        wr('h03, int'($urandom_range(1, 3)));
        wr('h11, int'($urandom_range(0, 255)));
        wr('h00, 5);
        idle(FRAME * 10);

        wr('h00, 1);
        wr('h04, 0);
        wr('h10, 128);
        wr('h11, int'($urandom_range(0, 255)));
        wr('h00, 3);
        idle(FRAME * 150);
        wr('h00, 1);
        wr('h04, 2);
        wr('h00, 3);
        idle(FRAME * 10);

        wr('h00, 1);
        idle(77);
        wr('h00, 0);
        idle(3);
        cyc(1'b0, 1'b0, 0, 0);
        idle(5);
        wr('h10, 100);
        wr('h12, 255);
        wr('h00, 1);
        idle(300);
        wr('h10 + CH, 99);
        wr('h1F, 99);
        idle(300);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
